// File: rtl/core_pkg.sv
// Shared definitions for the core pipeline stages.
// Contents:
//   CORE_DW / CORE_RW - default datapath/address width and register index width
//   OP_*              - opcodes the MEM stage needs to decode
//   mem_state_e       - MEM stage access state (IDLE / WAIT)
//   is_mem_op()       - true for opcodes that touch the data memory port
package core_pkg;

    localparam int CORE_DW = 16;
    localparam int CORE_RW = 3;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_ADI  = 4'b0001;
    localparam logic [3:0] OP_NAND = 4'b0010;
    localparam logic [3:0] OP_LW   = 4'b0100;
    localparam logic [3:0] OP_SW   = 4'b0101;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_e;

    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/flag_reg.sv
// Architectural carry/zero flag register with independent update enables.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset (flags clear to 0)
//   carry_we, carry_in  - load carry_in into the carry flag when carry_we is high
//   zero_we,  zero_in   - load zero_in into the zero flag when zero_we is high
//   carry, zero         - current flag values
module flag_reg (
    input  logic clk,
    input  logic rst_n,
    input  logic carry_we,
    input  logic carry_in,
    input  logic zero_we,
    input  logic zero_in,
    output logic carry,
    output logic zero
);

    logic carry_q, carry_d;
    logic zero_q,  zero_d;

    always_comb begin
        carry_d = carry_we ? carry_in : carry_q;
        zero_d  = zero_we  ? zero_in  : zero_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            carry_q <= carry_d;
            zero_q  <= zero_d;
        end
    end

    assign carry = carry_q;
    assign zero  = zero_q;

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: registers EX results for writeback, runs LW/SW on a
// req/ack data-memory port and owns the carry/zero flag register.
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   ex_*                       - instruction from EX; ex_ready is high only in IDLE
//   flush                      - kills the instruction being accepted or in flight
//   mem_req/we/addr/wdata      - memory request, held stable for the whole access
//   mem_rdata, mem_ack         - load data and one-cycle completion pulse
//   mem_err                    - one-cycle pulse when an access times out
//   wb_valid/en/rd/data        - registered writeback payload
//   prev_carry, prev_zero      - architectural flags fed back to the ALU
//   dbg_state                  - current access state, for observation only
// Handshake: an instruction is taken on a rising edge where ex_valid && ex_ready
// && !flush; nothing is taken otherwise, and EX must hold while ex_ready is low.
module mem_stage
    import core_pkg::*;
#(
    parameter int DW      = CORE_DW,
    parameter int RW      = CORE_RW,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ex_valid,
    output logic          ex_ready,
    input  logic [3:0]    ex_opcode,
    input  logic [DW-1:0] ex_result,
    input  logic [DW-1:0] ex_store_data,
    input  logic [RW-1:0] ex_rd,
    input  logic          ex_wb,
    input  logic          ex_carry,
    input  logic          ex_zero,
    input  logic          flush,
    output logic          mem_req,
    output logic          mem_we,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          mem_err,
    output logic          wb_valid,
    output logic          wb_en,
    output logic [RW-1:0] wb_rd,
    output logic [DW-1:0] wb_data,
    output logic          prev_carry,
    output logic          prev_zero,
    output mem_state_e    dbg_state
);

    // Last counter value before the access is abandoned: the counter starts at
    // 0 in the first WAIT cycle, so mem_req is high for exactly TIMEOUT cycles.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    mem_state_e    state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          kill_q, kill_d;
    logic          we_q, we_d;
    logic [DW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          lw_q, lw_d;
    logic [RW-1:0] rd_q, rd_d;
    logic          wbl_q, wbl_d;
    logic          wb_valid_q, wb_valid_d;
    logic          wb_en_q, wb_en_d;
    logic [RW-1:0] wb_rd_q, wb_rd_d;
    logic [DW-1:0] wb_data_q, wb_data_d;
    logic          err_q, err_d;

    logic accept;
    logic kill_eff;
    logic carry_we, zero_we, zero_in;

    assign ex_ready = (state_q == IDLE);
    assign accept   = ex_valid && ex_ready && !flush;
    // A flush arriving on the completion cycle itself still kills the result.
    assign kill_eff = kill_q || flush;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        kill_d     = kill_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        lw_d       = lw_q;
        rd_d       = rd_q;
        wbl_d      = wbl_q;
        wb_valid_d = 1'b0;
        wb_en_d    = 1'b0;
        wb_rd_d    = '0;
        wb_data_d  = '0;
        err_d      = 1'b0;
        carry_we   = 1'b0;
        zero_we    = 1'b0;
        zero_in    = (state_q == WAIT) ? (mem_rdata == '0) : ex_zero;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_mem_op(ex_opcode)) begin
                        state_d = WAIT;
                        cnt_d   = '0;
                        kill_d  = 1'b0;
                        we_d    = (ex_opcode == OP_SW);
                        addr_d  = ex_result;
                        wdata_d = ex_store_data;
                        lw_d    = (ex_opcode == OP_LW);
                        rd_d    = ex_rd;
                        wbl_d   = ex_wb;
                    end else begin
                        wb_valid_d = 1'b1;
                        wb_en_d    = ex_wb;
                        wb_rd_d    = ex_rd;
                        wb_data_d  = ex_result;
                        zero_we    = ex_wb && (ex_opcode == OP_ADD || ex_opcode == OP_ADI ||
                                               ex_opcode == OP_NAND);
                        carry_we   = ex_wb && (ex_opcode == OP_ADD || ex_opcode == OP_ADI);
                    end
                end
            end
            WAIT: begin
                if (mem_ack) begin
                    state_d    = IDLE;
                    cnt_d      = '0;
                    kill_d     = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    if (lw_q) begin
                        wb_data_d = mem_rdata;
                        wb_en_d   = wbl_q && !kill_eff;
                        zero_we   = !kill_eff;
                    end
                end else if (cnt_q >= CNT_LAST) begin
                    state_d    = IDLE;
                    cnt_d      = '0;
                    kill_d     = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    err_d      = 1'b1;
                end else begin
                    cnt_d  = cnt_q + 8'd1;
                    kill_d = kill_eff;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            kill_q     <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            lw_q       <= 1'b0;
            rd_q       <= '0;
            wbl_q      <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_en_q    <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            kill_q     <= kill_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            lw_q       <= lw_d;
            rd_q       <= rd_d;
            wbl_q      <= wbl_d;
            wb_valid_q <= wb_valid_d;
            wb_en_q    <= wb_en_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            err_q      <= err_d;
        end
    end

    flag_reg u_flag_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .carry_we (carry_we),
        .carry_in (ex_carry),
        .zero_we  (zero_we),
        .zero_in  (zero_in),
        .carry    (prev_carry),
        .zero     (prev_zero)
    );

    // mem_req comes straight from the state flop so reset drops it at once.
    assign mem_req   = (state_q == WAIT);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_err   = err_q;
    assign wb_valid  = wb_valid_q;
    assign wb_en     = wb_en_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed steps followed by randomized
// instructions, checked against a transaction-level model of the stage.
module tb_mem_stage;
  import core_pkg::*;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ready;
  logic [3:0]  ex_opcode;
  logic [15:0] ex_result;
  logic [15:0] ex_store_data;
  logic [2:0]  ex_rd;
  logic        ex_wb;
  logic        ex_carry;
  logic        ex_zero;
  logic        flush;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        mem_err;
  logic        wb_valid;
  logic        wb_en;
  logic [2:0]  wb_rd;
  logic [15:0] wb_data;
  logic        prev_carry;
  logic        prev_zero;
  mem_state_e  dbg_state;

  int n_asserts = 0;
  int n_fail    = 0;

  // Architectural flag model
  logic m_carry = 1'b0;
  logic m_zero  = 1'b0;

  // clock / reset block
  always #5 clk = ~clk;

  mem_stage #(.DW(16), .RW(3), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ex_valid      (ex_valid),
    .ex_ready      (ex_ready),
    .ex_opcode     (ex_opcode),
    .ex_result     (ex_result),
    .ex_store_data (ex_store_data),
    .ex_rd         (ex_rd),
    .ex_wb         (ex_wb),
    .ex_carry      (ex_carry),
    .ex_zero       (ex_zero),
    .flush         (flush),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .mem_ack       (mem_ack),
    .mem_err       (mem_err),
    .wb_valid      (wb_valid),
    .wb_en         (wb_en),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .prev_carry    (prev_carry),
    .prev_zero     (prev_zero),
    .dbg_state     (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_carry"}, 32'(prev_carry), 32'(m_carry));
    check({tag, "_zero"},  32'(prev_zero),  32'(m_zero));
  endtask

  // Driver: one non-memory instruction, called at a negedge; returns at the
  // next negedge after checking the writeback, so calls chain back-to-back.
  task automatic do_alu(input logic [3:0] op, input logic [15:0] res, input logic [2:0] rd,
                        input logic wb, input logic c, input logic z, input logic fl);
    ex_valid = 1'b1; ex_opcode = op; ex_result = res; ex_rd = rd; ex_wb = wb;
    ex_carry = c; ex_zero = z; flush = fl;
    mem_ack = 1'($urandom_range(0, 1)); mem_rdata = 16'($urandom);
    check("alu_ready", 32'(ex_ready), 32'd1);
    @(posedge clk); #1;
    ex_valid = 1'b0; flush = 1'b0; mem_ack = 1'b0;
    if (!fl && wb) begin
      if (op == OP_ADD || op == OP_ADI || op == OP_NAND) m_zero = z;
      if (op == OP_ADD || op == OP_ADI) m_carry = c;
    end
    @(negedge clk);
    if (fl) begin
      check("alu_flush_valid", 32'(wb_valid), 32'd0);
    end else begin
      check("alu_valid", 32'(wb_valid), 32'd1);
      check("alu_en",    32'(wb_en),    32'(wb));
      check("alu_data",  32'(wb_data),  32'(res));
      check("alu_rd",    32'(wb_rd),    32'(rd));
    end
    check("alu_req", 32'(mem_req), 32'd0);
    check("alu_state", 32'(dbg_state), 32'(IDLE));
    check_flags("alu");
  endtask

  // Driver: one LW/SW. ack_k = WAIT cycle (1-based) in which mem_ack pulses;
  // values above TIMEOUT mean no ack. flush_k = WAIT cycle with flush, 0 = none.
  task automatic do_mem(input logic st, input logic [15:0] addr, input logic [15:0] data,
                        input logic [2:0] rd, input logic wb, input int ack_k,
                        input logic [15:0] rdata, input int flush_k);
    logic killed = 1'b0;
    logic acked  = 1'b0;
    logic [15:0] exp_data;
    logic exp_en;
    ex_valid = 1'b1; ex_opcode = st ? OP_SW : OP_LW; ex_result = addr; ex_store_data = data;
    ex_rd = rd; ex_wb = wb; ex_carry = 1'($urandom); ex_zero = 1'($urandom);
    flush = 1'b0; mem_ack = 1'b0;
    check("mem_accept_ready", 32'(ex_ready), 32'd1);
    @(posedge clk); #1;
    ex_valid = 1'b0; ex_opcode = 4'($urandom); ex_result = 16'($urandom);
    ex_store_data = 16'($urandom);
    for (int k = 1; k <= TIMEOUT; k++) begin
      @(negedge clk);
      check("wait_req",   32'(mem_req),   32'd1);
      check("wait_ready", 32'(ex_ready),  32'd0);
      check("wait_addr",  32'(mem_addr),  32'(addr));
      check("wait_we",    32'(mem_we),    32'(st));
      check("wait_wdata", 32'(mem_wdata), 32'(data));
      check("wait_wbv",   32'(wb_valid),  32'd0);
      flush = (k == flush_k);
      if (k == flush_k) killed = 1'b1;
      mem_ack = (k == ack_k);
      mem_rdata = (k == ack_k) ? rdata : 16'($urandom);
      ex_valid = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      mem_ack = 1'b0; flush = 1'b0; ex_valid = 1'b0;
      if (k == ack_k) begin
        acked = 1'b1;
        break;
      end
    end
    exp_data = 16'h0;
    exp_en   = 1'b0;
    if (acked && !st) begin
      exp_data = rdata;
      exp_en   = wb && !killed;
      if (!killed) m_zero = (rdata == 16'h0);
    end
    @(negedge clk);
    check("done_req",   32'(mem_req),   32'd0);
    check("done_valid", 32'(wb_valid),  32'd1);
    check("done_en",    32'(wb_en),     32'(exp_en));
    check("done_data",  32'(wb_data),   32'(exp_data));
    check("done_rd",    32'(wb_rd),     32'(rd));
    check("done_err",   32'(mem_err),   32'(!acked));
    check("done_ready", 32'(ex_ready),  32'd1);
    check_flags("done");
  endtask

  initial begin
    rst_n = 1'b0; ex_valid = 1'b0; ex_opcode = 4'h0; ex_result = 16'h0; ex_store_data = 16'h0;
    ex_rd = 3'h0; ex_wb = 1'b0; ex_carry = 1'b0; ex_zero = 1'b0; flush = 1'b0;
    mem_rdata = 16'h0; mem_ack = 1'b0;
    #1;
    check("rst_req",   32'(mem_req),    32'd0);
    check("rst_wbv",   32'(wb_valid),   32'd0);
    check("rst_err",   32'(mem_err),    32'd0);
    check("rst_addr",  32'(mem_addr),   32'd0);
    check("rst_carry", 32'(prev_carry), 32'd0);
    check("rst_zero",  32'(prev_zero),  32'd0);
    check("rst_state", 32'(dbg_state),  32'(IDLE));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: ADD producing zero and carry
    do_alu(OP_ADD, 16'h0000, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0);
    // 2: LW at 0x0040, ack in 3rd WAIT cycle with zero data
    do_mem(1'b0, 16'h0040, 16'h0, 3'd2, 1'b1, 3, 16'h0000, 0);
    // 3: SW 0xBEEF to 0x0010, ack in first WAIT cycle
    do_mem(1'b1, 16'h0010, 16'hBEEF, 3'd3, 1'b0, 1, 16'h5555, 0);
    // 4: LW with no ack, then immediate next instruction
    do_mem(1'b0, 16'h0022, 16'h0, 3'd4, 1'b1, TIMEOUT + 1, 16'h0, 0);
    do_alu(OP_NAND, 16'h00F0, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    // ack on the last possible cycle wins over timeout
    do_mem(1'b0, 16'h0033, 16'h0, 3'd6, 1'b1, TIMEOUT, 16'h0000, 0);
    // 5: flush during WAIT, later ack with nonzero data
    do_alu(OP_ADI, 16'h0000, 3'd1, 1'b1, 1'b0, 1'b1, 1'b0);
    do_mem(1'b0, 16'h0044, 16'h0, 3'd7, 1'b1, 4, 16'h1234, 2);
    // flush at accept drops an ALU op
    do_alu(OP_ADD, 16'h0001, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1);

    // 6: reset while in WAIT, then a stray ack
    ex_valid = 1'b1; ex_opcode = OP_LW; ex_result = 16'h0050; ex_wb = 1'b1; ex_rd = 3'd3;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_req", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    m_carry = 1'b0; m_zero = 1'b0;
    check("midrst_req",   32'(mem_req),   32'd0);
    check("midrst_addr",  32'(mem_addr),  32'd0);
    check("midrst_wbv",   32'(wb_valid),  32'd0);
    check("midrst_state", 32'(dbg_state), 32'(IDLE));
    check_flags("midrst");
    @(negedge clk);
    rst_n = 1'b1; mem_ack = 1'b1; mem_rdata = 16'h0000;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    check("postrst_req",   32'(mem_req),   32'd0);
    check("postrst_wbv",   32'(wb_valid),  32'd0);
    check("postrst_state", 32'(dbg_state), 32'(IDLE));
    check_flags("postrst");

    // randomized instruction mix
    for (int i = 0; i < 40; i++) begin
      int kind;
      kind = $urandom_range(0, 8);
      if (kind <= 5) begin
        logic [3:0] op;
        op = 4'($urandom_range(0, 15));
        if (op == OP_LW || op == OP_SW) op = 4'($urandom_range(0, 2));
        do_alu(op, 16'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
               ($urandom_range(0, 7) == 0));
      end else begin
        int ack_k, flush_k, last_k;
        ack_k   = $urandom_range(1, TIMEOUT + 2);
        last_k  = (ack_k > TIMEOUT) ? TIMEOUT : ack_k;
        flush_k = ($urandom_range(0, 3) == 0) ? $urandom_range(1, last_k) : 0;
        do_mem(kind == 8, 16'($urandom), 16'($urandom), 3'($urandom), 1'($urandom),
               ack_k, ($urandom_range(0, 2) == 0) ? 16'h0 : 16'($urandom), flush_k);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of the ALU (EX) in the 6-stage core: EX result -> MEM -> WB.
- Registers the EX result and passes ALU results through to writeback.
- Runs LW/SW on a req/ack data-memory port, using the ALU result as the address. Stalls EX while a memory access is outstanding.
- Owns the architectural carry/zero flag register that feeds prev_carry/prev_zero back to the ALU.

Parameters:
- DW, 16, datapath and address width
- RW, 3, register index width
- TIMEOUT, 15, maximum cycles waiting for mem_ack before the access is abandoned (1..255)

Ports:
- clk  in  1  core clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  EX presents an instruction this cycle
- ex_ready  out  1  stage can accept; equals (state==IDLE)
- ex_opcode  in  4  instruction opcode (LW=0100, SW=0101)
- ex_result  in  DW  ALU result (LW/SW effective address)
- ex_store_data  in  DW  SW data operand
- ex_rd  in  RW  destination register
- ex_wb  in  1  instruction writes a register
- ex_carry  in  1  ALU carry output
- ex_zero  in  1  ALU zero output
- flush  in  1  kill the instruction being accepted / in flight
- mem_req  out  1  memory request
- mem_we  out  1  1=store, 0=load
- mem_addr  out  DW  memory address
- mem_wdata  out  DW  store data
- mem_rdata  in  DW  load data, valid with mem_ack
- mem_ack  in  1  one-cycle completion pulse
- mem_err  out  1  one-cycle pulse when an access times out
- wb_valid  out  1  WB stage payload valid
- wb_en  out  1  register write enable
- wb_rd  out  RW  destination register
- wb_data  out  DW  writeback data
- prev_carry  out  1  architectural carry flag
- prev_zero  out  1  architectural zero flag

Behaviour:
- Reset: all outputs 0, state=IDLE, timeout counter=0, flags=0.
- Accept: ex_valid && ex_ready && !flush.
  - If flush is high at accept, the instruction is dropped: wb_valid=0 next cycle, flags unchanged.
- Non-memory op accepted in IDLE: next cycle wb_valid=1, wb_data=ex_result, wb_rd=ex_rd, wb_en=ex_wb. Latency 1.
- Memory op accepted in IDLE:
  - Next cycle: state=WAIT, mem_req=1, mem_we=(opcode==SW), mem_addr=ex_result, mem_wdata=ex_store_data. All latched, held stable until completion.
  - wb_valid=0 that cycle.
- WAIT:
  - ex_ready=0 and mem_req=1 every cycle.
  - Counter increments each WAIT cycle that mem_ack is low.
- Completion: on mem_ack in WAIT.
  - Next cycle: mem_req=0, state=IDLE, wb_valid=1.
  - LW: wb_data=mem_rdata (captured on the ack edge), wb_en=latched ex_wb.
  - SW: wb_en=0, wb_data=0.
  - Minimum load latency is 2 cycles (ack in the first WAIT cycle).
- mem_ack outside WAIT is ignored.
- Timeout: counter reaches TIMEOUT with no ack.
  - Next cycle: mem_req=0, mem_err=1 for one cycle, wb_valid=1, wb_en=0, state=IDLE, flags unchanged.
  - Ack and timeout in the same cycle: ack wins.
- Flush during WAIT:
  - The bus access is not aborted; mem_req stays high until ack or timeout.
  - A sticky kill bit forces wb_en=0 and blocks the flag update on completion.
  - The kill bit clears on return to IDLE.
- Flags: update in the cycle wb_valid is asserted for a non-killed instruction.
  - ADD/ADDI/NAND (0000/0001/0010) with ex_wb=1: zero <= ex_zero.
  - ADD/ADDI (0000/0001) with ex_wb=1: carry <= ex_carry.
  - LW: zero <= (mem_rdata==0); carry unchanged.
  - All other ops leave both flags unchanged.
  - Flags are captured at accept (ALU ops) or at ack (LW).
- Back-to-back: in IDLE one instruction per cycle, with no bubbles for non-memory ops.
- Asynchronous reset mid-WAIT: mem_req drops immediately; any outstanding ack after reset is ignored.

Decomposition:
- Shared package core_pkg:
  - opcode constants (OP_ADD, OP_ADI, OP_NAND, OP_LW, OP_SW)
  - DW/RW widths
  - mem_state enum {IDLE, WAIT}
- One natural sub-module: flag_reg, the carry/zero register with per-flag update enables, reused by any future flag-writing stage.

Test Plan:
1. ADD with ex_result=0x0000, ex_zero=1, ex_carry=1, ex_wb=1 -> next cycle wb_valid=1, wb_data=0, wb_en=1; prev_zero=1, prev_carry=1.
2. LW addr=0x0040, ack in 3rd WAIT cycle with mem_rdata=0x0000 -> mem_req high 3 cycles, mem_addr=0x0040 stable, ex_ready=0 throughout; wb_data=0x0000, prev_zero=1, prev_carry unchanged.
3. SW addr=0x0010, data=0xBEEF, ack in first WAIT cycle -> mem_we=1, mem_wdata=0xBEEF; wb_valid=1 with wb_en=0; flags unchanged.
4. LW with no ack, TIMEOUT=15 -> mem_req drops after 15 cycles; mem_err pulses once; wb_en=0; next instruction accepted the following cycle.
5. flush asserted during WAIT of an LW, ack later with rdata=0x1234 -> wb_valid=1, wb_en=0; prev_zero unchanged.
6. rst_n low while in WAIT, then an ack pulse after release -> all outputs 0 immediately; ack ignored; state IDLE.
